// File: rtl/axi_slave_read_channel.sv
// AXI3/AXI4 slave read responder: accepts one AR at a time, walks the burst address and
// returns each beat fetched from a ready/data backend on R with RID, RRESP and RLAST.
module axi_slave_read_channel #(
    parameter int ID_W   = 12,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   s_axi_arid,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic [7:0]        s_axi_arlen,
    input  logic [2:0]        s_axi_arsize,
    input  logic [1:0]        s_axi_arburst,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [ID_W-1:0]   s_axi_rid,
    output logic [DATA_W-1:0] s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rlast,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    input  logic              read_ready,
    output logic [ADDR_W-1:0] read_addr,
    input  logic [DATA_W-1:0] read_data
);
    localparam int         ADDR_LSB    = (DATA_W == 64) ? 3 : 2;
    localparam int         BLK_W       = ADDR_W - ADDR_LSB;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_RSVD  = 2'b11;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    generate
        if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
            $error("axi_slave_read_channel: DATA_W must be 32 or 64");
        end
    endgenerate

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_e;

    state_e            state_q;
    logic              arready_q;
    logic              rvalid_q;
    logic              rlast_q;
    logic [1:0]        rresp_q;
    logic [ID_W-1:0]   rid_q;
    logic [DATA_W-1:0] rdata_q;
    logic [ID_W-1:0]   tx_arid_q;
    logic [ADDR_W-1:0] tx_araddr_q;
    logic [7:0]        tx_arlen_q;
    logic [2:0]        tx_arsize_q;
    logic [1:0]        tx_arburst_q;
    logic              beats_left_q;

    logic              tx_ractive;
    logic              ar_hs;
    logic              r_hs;
    logic              beat_load;
    logic [BLK_W-1:0]  blk_next;
    logic [ADDR_W-1:0] tx_araddr_d;
    logic              unused_arsize;

    assign tx_ractive = (state_q == ST_ACTIVE);
    assign ar_hs      = s_axi_arvalid & arready_q;
    assign r_hs       = rvalid_q & s_axi_rready;
    assign beat_load  = tx_ractive & read_ready & beats_left_q & (~rvalid_q | s_axi_rready);

    // INCR beats after the first land on the next DATA_W-aligned address, wrapping at 2^ADDR_W.
    assign blk_next    = tx_araddr_q[ADDR_W-1:ADDR_LSB] + {{(BLK_W-1){1'b0}}, 1'b1};
    assign tx_araddr_d = {blk_next, {ADDR_LSB{1'b0}}};

    // ARSIZE is held with the transaction but does not steer addressing.
    assign unused_arsize = ^tx_arsize_q;

    // NOTE: every register here uses <= so all branches observe pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            arready_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rlast_q      <= 1'b0;
            rresp_q      <= RESP_OKAY;
            rid_q        <= '0;
            rdata_q      <= '0;
            tx_arid_q    <= '0;
            tx_araddr_q  <= '0;
            tx_arlen_q   <= '0;
            tx_arsize_q  <= '0;
            tx_arburst_q <= '0;
            beats_left_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    arready_q <= ~ar_hs;
                    if (ar_hs) begin
                        tx_arid_q    <= s_axi_arid;
                        tx_araddr_q  <= s_axi_araddr;
                        tx_arlen_q   <= s_axi_arlen;
                        tx_arsize_q  <= s_axi_arsize;
                        tx_arburst_q <= s_axi_arburst;
                        beats_left_q <= 1'b1;
                        state_q      <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    arready_q <= 1'b0;
                    if (beat_load) begin
                        rdata_q  <= read_data;
                        rvalid_q <= 1'b1;
                        rlast_q  <= (tx_arlen_q == 8'd0);
                        rresp_q  <= (tx_arburst_q == BURST_RSVD) ? RESP_SLVERR : RESP_OKAY;
                        rid_q    <= tx_arid_q;
                        if (tx_arburst_q == BURST_INCR) begin
                            tx_araddr_q <= tx_araddr_d;
                        end
                        if (tx_arlen_q != 8'd0) begin
                            tx_arlen_q <= tx_arlen_q - 8'd1;
                        end else begin
                            beats_left_q <= 1'b0;
                        end
                    end else if (r_hs) begin
                        rvalid_q <= 1'b0;
                        if (rlast_q) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rid     = rid_q;
    assign s_axi_rdata   = rdata_q;
    assign read_addr     = tx_araddr_q;

endmodule

// File: tb/tb_axi_slave_read_channel.sv
// Bench for axi_slave_read_channel: directed bursts plus random ones, checked against a
// beat-list model computed from base address, length and burst type.
module tb_axi_slave_read_channel;
    localparam int ID_W   = 12;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BYTES  = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [ID_W-1:0]   s_axi_arid;
    logic [ADDR_W-1:0] s_axi_araddr;
    logic [7:0]        s_axi_arlen;
    logic [2:0]        s_axi_arsize;
    logic [1:0]        s_axi_arburst;
    logic              s_axi_arvalid;
    logic              s_axi_arready;
    logic [ID_W-1:0]   s_axi_rid;
    logic [DATA_W-1:0] s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rlast;
    logic              s_axi_rvalid;
    logic              s_axi_rready;
    logic              read_ready;
    logic [ADDR_W-1:0] read_addr;
    logic [DATA_W-1:0] read_data;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int ar_cyc = 0;
    int last_rlast_cyc = 0;

    axi_slave_read_channel #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axi_arid    (s_axi_arid),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_arsize  (s_axi_arsize),
        .s_axi_arburst (s_axi_arburst),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rid     (s_axi_rid),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rlast   (s_axi_rlast),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .read_ready    (read_ready),
        .read_addr     (read_addr),
        .read_data     (read_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Backend memory: every address holds a fixed pseudo-random word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction
    assign read_data = mem_word(read_addr);

    // Address of beat i: INCR beats after the first sit at aligned base + i*BYTES.
    function automatic logic [31:0] beat_addr(input logic [31:0] base, input logic [1:0] burst,
                                              input int i);
        if (burst != 2'b01 || i == 0) return base;
        return (base & ~32'(BYTES - 1)) + 32'(i * BYTES);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_ar(input logic [ID_W-1:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
        bit ok = 1'b0;
        s_axi_arid    = id;
        s_axi_araddr  = addr;
        s_axi_arlen   = len;
        s_axi_arsize  = 3'd2;
        s_axi_arburst = burst;
        s_axi_arvalid = 1'b1;
        for (int n = 0; n < 64; n++) begin
            if (s_axi_arready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("ar accepted", 64'(ok), 64'(1));
        ar_cyc = cyc + 1;
        tick();
        s_axi_arvalid = 1'b0;
        check("read_addr after ar", 64'(read_addr), 64'(addr));
    endtask

    // mode 0: rready/read_ready high; 1: rready toggles; 2: both random.
    task automatic collect(input logic [ID_W-1:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] burst,
                           input int mode, input bit ar_busy, input int abort_at);
        int          beat    = 0;
        bit          done    = 1'b0;
        bit          stall   = 1'b0;
        bit          aborted = 1'b0;
        logic [47:0] held    = '0;
        logic [47:0] now_v;
        logic [31:0] ea;
        for (int n = 0; n < 600 && !done; n++) begin
            if (abort_at >= 0 && beat == abort_at && s_axi_rvalid === 1'b1) begin
                rst     = 1'b1;
                aborted = 1'b1;
                break;
            end
            case (mode)
                0: begin s_axi_rready = 1'b1; read_ready = 1'b1; end
                1: begin s_axi_rready = ((n % 2) == 1); read_ready = 1'b1; end
                default: begin
                    s_axi_rready = ($urandom_range(0, 1) == 1);
                    read_ready   = ($urandom_range(0, 1) == 1);
                end
            endcase
            now_v = {s_axi_rvalid, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast};
            if (stall) check($sformatf("stall hold beat%0d", beat), 64'(now_v), 64'(held));
            if (ar_busy) check("arready low while busy", 64'(s_axi_arready), 64'(0));
            stall = 1'b0;
            if (s_axi_rvalid === 1'b1) begin
                if (s_axi_rready) begin
                    if (beat > int'(len)) begin
                        check("extra beat", 64'(beat), 64'(len));
                    end else begin
                        ea = beat_addr(addr, burst, beat);
                        check($sformatf("beat%0d rid", beat), 64'(s_axi_rid), 64'(id));
                        check($sformatf("beat%0d rdata", beat), 64'(s_axi_rdata), 64'(mem_word(ea)));
                        check($sformatf("beat%0d rresp", beat), 64'(s_axi_rresp),
                              64'((burst == 2'b11) ? 2'b10 : 2'b00));
                        check($sformatf("beat%0d rlast", beat), 64'(s_axi_rlast),
                              64'(beat == int'(len)));
                        if (mode == 0)
                            check($sformatf("beat%0d cycle", beat), 64'(cyc + 1),
                                  64'(ar_cyc + 2 + beat));
                    end
                    beat++;
                    if (s_axi_rlast === 1'b1) begin
                        done = 1'b1;
                        last_rlast_cyc = cyc + 1;
                    end
                end else begin
                    stall = 1'b1;
                    held  = now_v;
                end
            end
            tick();
        end
        if (abort_at >= 0) begin
            check("abort point reached", 64'(aborted), 64'(1));
        end else begin
            check("burst completed", 64'(done), 64'(1));
            check("beat count", 64'(beat), 64'(int'(len) + 1));
            check("arready low after rlast", 64'(s_axi_arready), 64'(0));
            check("rvalid low after rlast", 64'(s_axi_rvalid), 64'(0));
            tick();
            check("arready back in idle", 64'(s_axi_arready), 64'(1));
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int q;
        rst = 1'b1;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
        s_axi_arburst = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0; read_ready = 1'b0;
        repeat (3) tick();
        check("reset arready", 64'(s_axi_arready), 64'(0));
        check("reset rvalid", 64'(s_axi_rvalid), 64'(0));
        check("reset rlast", 64'(s_axi_rlast), 64'(0));
        check("reset rresp", 64'(s_axi_rresp), 64'(0));
        check("reset rid", 64'(s_axi_rid), 64'(0));
        check("reset rdata", 64'(s_axi_rdata), 64'(0));
        check("reset read_addr", 64'(read_addr), 64'(0));
        rst = 1'b0;
        check("arready first cycle", 64'(s_axi_arready), 64'(0));
        tick();
        check("arready second cycle", 64'(s_axi_arready), 64'(1));

        // Single beat, INCR, arlen=0.
        do_ar(12'h005, 32'h0000_0100, 8'd0, 2'b01);
        collect(12'h005, 32'h0000_0100, 8'd0, 2'b01, 0, 1'b0, -1);

        // Four-beat INCR from an unaligned start.
        do_ar(12'h0A7, 32'h0000_1002, 8'd3, 2'b01);
        collect(12'h0A7, 32'h0000_1002, 8'd3, 2'b01, 0, 1'b0, -1);

        // Backpressure with rready toggling.
        do_ar(12'h033, 32'h0000_2000, 8'd2, 2'b01);
        collect(12'h033, 32'h0000_2000, 8'd2, 2'b01, 1, 1'b0, -1);

        // FIXED, WRAP (held like FIXED) and reserved burst types.
        do_ar(12'h007, 32'h0000_3004, 8'd3, 2'b00);
        collect(12'h007, 32'h0000_3004, 8'd3, 2'b00, 0, 1'b0, -1);
        do_ar(12'h009, 32'h0000_5008, 8'd2, 2'b10);
        collect(12'h009, 32'h0000_5008, 8'd2, 2'b10, 0, 1'b0, -1);
        do_ar(12'h008, 32'h0000_4000, 8'd1, 2'b11);
        collect(12'h008, 32'h0000_4000, 8'd1, 2'b11, 0, 1'b0, -1);

        // Address increment wrapping past 2^32.
        do_ar(12'h1FF, 32'hFFFF_FFF8, 8'd3, 2'b01);
        collect(12'h1FF, 32'hFFFF_FFF8, 8'd3, 2'b01, 0, 1'b0, -1);

        // Second AR held valid while a burst is active.
        do_ar(12'h111, 32'h0000_6000, 8'd2, 2'b01);
        s_axi_arid = 12'h222; s_axi_araddr = 32'h0000_7000; s_axi_arlen = 8'd1;
        s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
        collect(12'h111, 32'h0000_6000, 8'd2, 2'b01, 0, 1'b1, -1);
        q = last_rlast_cyc;
        do_ar(12'h222, 32'h0000_7000, 8'd1, 2'b01);
        check("second ar cycle", 64'(ar_cyc), 64'(q + 2));
        collect(12'h222, 32'h0000_7000, 8'd1, 2'b01, 0, 1'b0, -1);

        // Reset asserted while beat 2 of an 8-beat burst is presented.
        do_ar(12'h066, 32'h0000_8000, 8'd7, 2'b01);
        collect(12'h066, 32'h0000_8000, 8'd7, 2'b01, 0, 1'b0, 1);
        tick();
        check("rvalid after mid reset", 64'(s_axi_rvalid), 64'(0));
        check("arready after mid reset", 64'(s_axi_arready), 64'(0));
        rst = 1'b0;
        tick();
        check("arready after reset release", 64'(s_axi_arready), 64'(1));
        do_ar(12'h067, 32'h0000_9000, 8'd2, 2'b01);
        collect(12'h067, 32'h0000_9000, 8'd2, 2'b01, 0, 1'b0, -1);

        // Random bursts with random backpressure and backend stalls.
        for (int i = 0; i < 24; i++) begin
            logic [ID_W-1:0] rid_r;
            logic [31:0]     addr_r;
            logic [7:0]      len_r;
            logic [1:0]      burst_r;
            rid_r   = ID_W'($urandom);
            addr_r  = ((i % 6) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
            len_r   = 8'($urandom_range(0, 12));
            burst_r = 2'($urandom_range(0, 3));
            do_ar(rid_r, addr_r, len_r, burst_r);
            collect(rid_r, addr_r, len_r, burst_r, 2, 1'b0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
